// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first, start/busy/done handshake.
// Optional macro BCD2BIN_ERR_ABORT_EN: an illegal digit ends the conversion on the edge it is seen.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [4*DIGITS-1:0]   r_shift;
    logic [BIN_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err_acc;

    logic                  r_busy;
    logic                  r_done;
    logic [BIN_W-1:0]      r_bin;
    logic                  r_err;

    logic [3:0]            w_top;
    logic                  w_bad;
    logic                  w_last;
    logic                  w_finish;
    logic                  w_load;
    logic [BIN_W-1:0]      w_acc_nxt;
    logic                  w_err_nxt;

    // acc*10 built from two shifts; the sum wraps at BIN_W bits by construction
    function automatic logic [BIN_W-1:0] mul10_add(input logic [BIN_W-1:0] a,
                                                   input logic [3:0]       d);
        logic [BIN_W-1:0] t;
        t = (a << 3) + (a << 1);
        return t + BIN_W'(d);
    endfunction

    assign w_top     = r_shift[4*DIGITS-1 -: 4];
    assign w_bad     = (w_top > 4'd9);
    assign w_last    = (r_cnt == LAST_IDX);
    assign w_acc_nxt = mul10_add(r_acc, w_top);
    assign w_err_nxt = r_err_acc | w_bad;
    assign w_load    = start && (r_state != S_CONV);

`ifdef BCD2BIN_ERR_ABORT_EN
    assign w_finish  = w_last | w_bad;
`else
    assign w_finish  = w_last;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CONV;
            S_CONV:  if (w_finish) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_CONV : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: reloaded on every accepted start, so it carries no reset
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_shift   <= bcd_in;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
        end else if (r_state == S_CONV) begin
            r_shift   <= r_shift << 4;
            r_acc     <= w_acc_nxt;
            r_cnt     <= r_cnt + CNT_W'(1);
            r_err_acc <= w_err_nxt;
        end
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bin   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_CONV);
            r_done  <= (r_state == S_CONV) && w_finish;
            if ((r_state == S_CONV) && w_finish) begin
                r_bin <= w_err_nxt ? '0 : w_acc_nxt;
                r_err <= w_err_nxt;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bin_out = r_bin;
    assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: a 4-digit instance for handshake/latency/reset scenarios
// and a 2-digit instance for the exhaustive back-to-back code sweep.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start1;
    logic [15:0] bcd1;
    logic        busy1, done1, err1;
    logic [13:0] bin1;

    logic        start2;
    logic [7:0]  bcd2;
    logic        busy2, done2, err2;
    logic [6:0]  bin2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) u_dut4 (
        .clk(clk), .rst(rst), .start(start1), .bcd_in(bcd1),
        .busy(busy1), .done(done1), .bin_out(bin1), .err(err1)
    );

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .bcd_in(bcd2),
        .busy(busy2), .done(done2), .bin_out(bin2), .err(err2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle on the 4-digit instance and collect what comes back.
    task automatic do_conv(input logic [15:0] code, output int lat, output logic [13:0] bin,
                           output logic e, output logic busy_ok, output logic pulse_ok);
        start1 = 1'b1;
        bcd1   = code;
        tick();
        start1 = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (done1 !== 1'b1 && lat < 20) begin
            if (busy1 !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (busy1 !== 1'b0) busy_ok = 1'b0;
        bin = bin1;
        e   = err1;
        tick();
        pulse_ok = (done1 === 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1; start1 = 1'b0; bcd1 = '0; start2 = 1'b0; bcd2 = '0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy1, done1, bin1, err1} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_dut4 got busy=%b done=%b bin=%0d err=%b exp all 0", busy1, done1, bin1, err1);
        end
        n_cmp++;
        if ({busy2, done2, bin2, err2} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_dut2 got busy=%b done=%b bin=%0d err=%b exp all 0", busy2, done2, bin2, err2);
        end
    endtask

    task automatic test_legal;
        logic [15:0] codes [3] = '{16'h9999, 16'h0000, 16'h0105};
        int          exps  [3] = '{9999, 0, 105};
        int lat; logic [13:0] bin; logic e, bok, pok;
        for (int i = 0; i < 3; i++) begin
            do_conv(codes[i], lat, bin, e, bok, pok);
            n_cmp++;
            if (bin !== 14'(exps[i]) || e !== 1'b0) begin
                n_bad++;
                $display("FAIL legal_%h got bin=%0d err=%b exp bin=%0d err=0", codes[i], bin, e, exps[i]);
            end
            n_cmp++;
            if (lat != 4) begin
                n_bad++;
                $display("FAIL latency_%h got %0d exp 4", codes[i], lat);
            end
            n_cmp++;
            if (!bok || !pok) begin
                n_bad++;
                $display("FAIL handshake_%h got busy_ok=%b pulse_ok=%b exp 1 1", codes[i], bok, pok);
            end
        end
    endtask

    task automatic test_illegal;
        int lat; logic [13:0] bin; logic e, bok, pok;
        int exp_lat;
`ifdef BCD2BIN_ERR_ABORT_EN
        exp_lat = 3;
`else
        exp_lat = 4;
`endif
        do_conv(16'h12A4, lat, bin, e, bok, pok);
        n_cmp++;
        if (bin !== 14'd0 || e !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_12A4 got bin=%0d err=%b exp bin=0 err=1", bin, e);
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL illegal_latency got %0d exp %0d", lat, exp_lat);
        end
    endtask

    task automatic test_start_ignored;
        start1 = 1'b1; bcd1 = 16'h0042;
        tick();
        bcd1 = 16'h0077;
        tick(); tick(); tick();
        n_cmp++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_hold got busy=%b done=%b exp 1 0", busy1, done1);
        end
        tick();
        start1 = 1'b0;
        n_cmp++;
        if (done1 !== 1'b1 || bin1 !== 14'd42 || err1 !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_start got done=%b bin=%0d err=%b exp 1 42 0", done1, bin1, err1);
        end
        tick();
        n_cmp++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || bin1 !== 14'd42) begin
            n_bad++;
            $display("FAIL after_done got done=%b busy=%b bin=%0d exp 0 0 42", done1, busy1, bin1);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [13:0] bin; logic e, bok, pok;
        logic saw_done;
        start1 = 1'b1; bcd1 = 16'h5678;
        tick();
        start1 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy1, done1, bin1, err1} !== 17'd0) begin
            n_bad++;
            $display("FAIL rst_mid got busy=%b done=%b bin=%0d err=%b exp all 0", busy1, done1, bin1, err1);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done1 === 1'b1 || busy1 === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_no_done got activity=%b exp 0", saw_done);
        end
        do_conv(16'h0310, lat, bin, e, bok, pok);
        n_cmp++;
        if (bin !== 14'd310 || e !== 1'b0 || lat != 4) begin
            n_bad++;
            $display("FAIL after_rst got bin=%0d err=%b lat=%0d exp 310 0 4", bin, e, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] codes[$];
        logic [7:0] c;
        int         w;
        logic [6:0] exp_bin;
        logic       exp_err;
        for (int h = 0; h < 10; h++)
            for (int l = 0; l < 10; l++)
                codes.push_back(8'((h << 4) | l));
        for (int v = 0; v < 256; v++) begin
            c = 8'(v);
            if (c[7:4] > 4'd9 || c[3:0] > 4'd9) codes.push_back(c);
        end
        bcd2   = codes[0];
        start2 = 1'b1;
        tick();
        for (int i = 0; i < codes.size(); i++) begin
            c = codes[i];
            w = 0;
            while (done2 !== 1'b1 && w < 10) begin
                tick();
                w++;
            end
            exp_err = (c[7:4] > 4'd9) || (c[3:0] > 4'd9);
            exp_bin = exp_err ? 7'd0 : 7'(c[7:4] * 10 + c[3:0]);
            n_cmp++;
            if (bin2 !== exp_bin || err2 !== exp_err || busy2 !== 1'b0) begin
                n_bad++;
                $display("FAIL sweep_%h got bin=%0d err=%b busy=%b exp bin=%0d err=%b busy=0",
                         c, bin2, err2, busy2, exp_bin, exp_err);
            end
            if (!exp_err) begin
                n_cmp++;
                if (w != 2) begin
                    n_bad++;
                    $display("FAIL sweep_lat_%h got %0d exp 2", c, w);
                end
            end
            if (i + 1 < codes.size()) bcd2 = codes[i + 1];
            else start2 = 1'b0;
            tick();
        end
        tick();
        n_cmp++;
        if (busy2 !== 1'b0 || done2 !== 1'b0) begin
            n_bad++;
            $display("FAIL sweep_end got busy=%b done=%b exp 0 0", busy2, done2);
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_illegal();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
